// File: rtl/alu_project_pkg.sv
// alu_project_pkg: opcode and screen selects plus the active-low 7-segment code table.
// The segment patterns use bit order {g,f,e,d,c,b,a}.
package alu_project_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [1:0] SCR_A     = 2'd0;
    localparam logic [1:0] SCR_B     = 2'd1;
    localparam logic [1:0] SCR_RES   = 2'd2;
    localparam logic [1:0] SCR_FLAGS = 2'd3;
    // Element [n] holds the pattern for digit n.
    localparam logic [9:0][6:0] SEG_CODES = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/alu_project_seven_seg_decoder.sv
// seven_seg_decoder: 4-bit digit to active-low gfedcba pattern; values 10-15 are blank.
module seven_seg_decoder
    import alu_project_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = (digit < 4'd10) ? SEG_CODES[digit] : SEG_BLANK;
endmodule

// File: rtl/alu_project.sv
// alu_project: 4-bit registered ALU with a three-digit 7-segment readout.
// The readout reflects this cycle's operands, result and flags, so it shares the ALU's one-cycle latency.
module alu_project
    import alu_project_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] opcode,
    input  logic [1:0] screen,
    input  logic       carry_in,
    output logic [7:0] result,
    output logic       carry_out,
    output logic       overflow,
    output logic [6:0] seg_1,
    output logic [6:0] seg_2,
    output logic [6:0] seg_3,
    output logic [3:0] display_1,
    output logic [3:0] display_2,
    output logic [3:0] display_3
);
    logic [4:0] sum;
    logic [7:0] diff, prod, shown, res_d, res_q;
    logic       borrow, cout_d, cout_q, ovf_d, ovf_q;
    logic [3:0] d1_d, d2_d, d3_d, d1_q, d2_q, d3_q;
    logic [6:0] raw_1, raw_2, raw_3;

    assign sum    = {1'b0, A} + {1'b0, B} + {4'b0, carry_in};
    assign diff   = {4'b0, A} - {4'b0, B} - {7'b0, carry_in};
    assign borrow = {1'b0, A} < ({1'b0, B} + {4'b0, carry_in});
    assign prod   = {4'b0, A} * {4'b0, B};

    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (opcode)
            OP_ADD: begin res_d = {3'b0, sum}; cout_d = sum[4]; ovf_d = sum > 5'd15; end
            OP_SUB: begin res_d = diff; cout_d = borrow; ovf_d = borrow; end
            OP_MUL: begin res_d = prod; ovf_d = prod > 8'd15; end
            OP_AND: res_d = {4'b0, A & B};
            OP_OR:  res_d = {4'b0, A | B};
            OP_XOR: res_d = {4'b0, A ^ B};
            default: ;
        endcase
    end

    always_comb begin
        shown = screen == SCR_A ? {4'b0, A} : screen == SCR_B ? {4'b0, B} : res_d;
        d1_d  = screen == SCR_FLAGS ? {3'b0, cout_d} : 4'(shown / 8'd100);
        d2_d  = screen == SCR_FLAGS ? {3'b0, ovf_d}  : 4'((shown / 8'd10) % 8'd10);
        d3_d  = screen == SCR_FLAGS ? {1'b0, opcode} : 4'(shown % 8'd10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
        end else begin
            res_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            d3_q   <= d3_d;
        end
    end

    // Segments decode the registered digits, so they stay a pure function of flops.
    seven_seg_decoder u_dec_1 (.digit(d1_q), .seg(raw_1));
    seven_seg_decoder u_dec_2 (.digit(d2_q), .seg(raw_2));
    seven_seg_decoder u_dec_3 (.digit(d3_q), .seg(raw_3));

    assign seg_1     = SEG_ACTIVE_LOW ? raw_1 : ~raw_1;
    assign seg_2     = SEG_ACTIVE_LOW ? raw_2 : ~raw_2;
    assign seg_3     = SEG_ACTIVE_LOW ? raw_3 : ~raw_3;
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign display_1 = d1_q;
    assign display_2 = d2_q;
    assign display_3 = d3_q;
endmodule

// File: tb/tb_alu_project.sv
// tb_alu_project: directed vectors with hand-computed expectations for alu_project.
module tb_alu_project;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = '0, B = '0;
    logic [2:0] opcode = '0;
    logic [1:0] screen = '0;
    logic       carry_in = 1'b0;
    logic [7:0] result;
    logic       carry_out, overflow;
    logic [6:0] seg_1, seg_2, seg_3;
    logic [3:0] display_1, display_2, display_3;
    int n_cmp = 0;
    int n_err = 0;

    alu_project dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .screen(screen),
        .carry_in(carry_in), .result(result), .carry_out(carry_out), .overflow(overflow),
        .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3),
        .display_1(display_1), .display_2(display_2), .display_3(display_3)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [1:0] scr, input logic cin);
        rst = r; A = a; B = b; opcode = op; screen = scr; carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {result, carry_out, overflow} and the three digits packed for compact checks.
    function automatic logic [20:0] alu3(input logic [7:0] r, input logic c, input logic o);
        return {11'b0, r, c, o};
    endfunction

    function automatic logic [20:0] dig3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {9'b0, a, b, c};
    endfunction

    initial begin
        step(1, 4'd9, 4'd9, 3'b000, 2'b10, 1);
        chk("reset_alu", alu3(result, carry_out, overflow), alu3(8'd0, 0, 0));
        chk("reset_disp", dig3(display_1, display_2, display_3), dig3(0, 0, 0));
        chk("reset_seg", {seg_1, seg_2, seg_3}, {7'b1000000, 7'b1000000, 7'b1000000});

        step(0, 4'd5, 4'd3, 3'b000, 2'b10, 0);
        chk("add_5_3", alu3(result, carry_out, overflow), alu3(8'd8, 0, 0));
        chk("add_5_3_disp", dig3(display_1, display_2, display_3), dig3(0, 0, 8));
        chk("add_5_3_seg", {seg_1, seg_3}, {7'b1000000, 7'b0000000});

        step(0, 4'd15, 4'd5, 3'b000, 2'b10, 0);
        chk("add_15_5", alu3(result, carry_out, overflow), alu3(8'd20, 1, 1));
        chk("add_15_5_disp", dig3(display_1, display_2, display_3), dig3(0, 2, 0));
        chk("add_15_5_seg2", {14'b0, seg_2}, {14'b0, 7'b0100100});

        step(0, 4'd15, 4'd5, 3'b000, 2'b11, 1);
        chk("add_cin", alu3(result, carry_out, overflow), alu3(8'd21, 1, 1));
        chk("flags_disp", dig3(display_1, display_2, display_3), dig3(1, 1, 0));
        chk("flags_seg", {seg_1, seg_2, seg_3}, {7'b1111001, 7'b1111001, 7'b1000000});

        step(0, 4'd2, 4'd10, 3'b001, 2'b10, 0);
        chk("sub_2_10", alu3(result, carry_out, overflow), alu3(8'hF8, 1, 1));
        chk("sub_2_10_disp", dig3(display_1, display_2, display_3), dig3(2, 4, 8));

        step(0, 4'd9, 4'd6, 3'b001, 2'b10, 1);
        chk("sub_9_6_cin", alu3(result, carry_out, overflow), alu3(8'd2, 0, 0));

        step(0, 4'd0, 4'd15, 3'b001, 2'b10, 1);
        chk("sub_0_15_cin", alu3(result, carry_out, overflow), alu3(8'hF0, 1, 1));
        chk("sub_0_15_disp", dig3(display_1, display_2, display_3), dig3(2, 4, 0));

        step(0, 4'd5, 4'd5, 3'b001, 2'b10, 0);
        chk("sub_equal", alu3(result, carry_out, overflow), alu3(8'd0, 0, 0));

        step(0, 4'd10, 4'd12, 3'b010, 2'b10, 1);
        chk("mul_10_12", alu3(result, carry_out, overflow), alu3(8'd120, 0, 1));
        chk("mul_disp", dig3(display_1, display_2, display_3), dig3(1, 2, 0));
        chk("mul_seg1", {14'b0, seg_1}, {14'b0, 7'b1111001});

        step(0, 4'd15, 4'd15, 3'b010, 2'b10, 0);
        chk("mul_15_15", alu3(result, carry_out, overflow), alu3(8'd225, 0, 1));
        chk("mul_max_disp", dig3(display_1, display_2, display_3), dig3(2, 2, 5));

        step(0, 4'd3, 4'd2, 3'b010, 2'b10, 0);
        chk("mul_3_2", alu3(result, carry_out, overflow), alu3(8'd6, 0, 0));

        step(0, 4'b1010, 4'b1011, 3'b011, 2'b10, 1);
        chk("and", alu3(result, carry_out, overflow), alu3(8'd10, 0, 0));

        step(0, 4'b0101, 4'b0010, 3'b100, 2'b10, 1);
        chk("or", alu3(result, carry_out, overflow), alu3(8'd7, 0, 0));
        chk("or_seg3", {14'b0, seg_3}, {14'b0, 7'b1111000});

        step(0, 4'b0110, 4'b1001, 3'b101, 2'b10, 0);
        chk("xor", alu3(result, carry_out, overflow), alu3(8'd15, 0, 0));

        step(0, 4'd15, 4'd15, 3'b110, 2'b10, 1);
        chk("op110", alu3(result, carry_out, overflow), alu3(8'd0, 0, 0));

        step(0, 4'd15, 4'd15, 3'b111, 2'b11, 1);
        chk("op111", alu3(result, carry_out, overflow), alu3(8'd0, 0, 0));
        chk("op111_flags_disp", dig3(display_1, display_2, display_3), dig3(0, 0, 7));

        step(0, 4'd12, 4'd7, 3'b000, 2'b00, 0);
        chk("screen_a", dig3(display_1, display_2, display_3), dig3(0, 1, 2));
        chk("screen_a_seg", {seg_2, seg_3}, {7'b1111001, 7'b0100100});

        step(0, 4'd12, 4'd7, 3'b000, 2'b01, 0);
        chk("screen_b", dig3(display_1, display_2, display_3), dig3(0, 0, 7));
        chk("screen_b_res", alu3(result, carry_out, overflow), alu3(8'd19, 1, 1));

        step(1, 4'd15, 4'd5, 3'b000, 2'b10, 1);
        chk("midrst_alu", alu3(result, carry_out, overflow), alu3(8'd0, 0, 0));
        chk("midrst_disp", dig3(display_1, display_2, display_3), dig3(0, 0, 0));
        chk("midrst_seg", {seg_1, seg_2, seg_3}, {7'b1000000, 7'b1000000, 7'b1000000});

        step(0, 4'd15, 4'd5, 3'b000, 2'b10, 0);
        chk("post_rst", alu3(result, carry_out, overflow), alu3(8'd20, 1, 1));
        chk("post_rst_disp", dig3(display_1, display_2, display_3), dig3(0, 2, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
